// File: rtl/sram_axi_bridge_pkg.sv
// Shared types and helpers for the SRAM-to-AXI3 bridge: FSM states, AXI size
// codes and the kseg address map.
package mem_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_AR,
    RD_R,
    WR_AW_W,
    WR_B
  } state_e;

  localparam logic [2:0] AXI_SIZE_1B = 3'd0;
  localparam logic [2:0] AXI_SIZE_2B = 3'd1;
  localparam logic [2:0] AXI_SIZE_4B = 3'd2;
  localparam logic [2:0] AXI_SIZE_8B = 3'd3;

  localparam logic [31:0] KSEG_BASE = 32'h8000_0000;
  localparam logic [31:0] KSEG_MASK = 32'h1FFF_FFFF;

  function automatic logic [2:0] to_axi_size(input logic [1:0] sz);
    case (sz)
      2'd0:    return AXI_SIZE_1B;
      2'd1:    return AXI_SIZE_2B;
      2'd2:    return AXI_SIZE_4B;
      default: return AXI_SIZE_8B;
    endcase
  endfunction

  // kseg0/kseg1 (0x8000_0000..0xBFFF_FFFF) fold onto physical low memory.
  function automatic logic [31:0] kseg_map(input logic [31:0] addr);
    if ((addr & 32'hC000_0000) == KSEG_BASE) return addr & KSEG_MASK;
    return addr;
  endfunction

endpackage

// File: rtl/sram_axi_bridge_if.sv
// Bus interfaces of the bridge: sram_if (CPU master -> bridge slave) and
// axi_if (bridge master -> AXI3 slave).
interface sram_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [NUM_CH-1:0]            m_req;
  logic [NUM_CH-1:0]            m_wr;
  logic [2*NUM_CH-1:0]          m_size;
  logic [ADDR_W*NUM_CH-1:0]     m_addr;
  logic [DATA_W*NUM_CH-1:0]     m_wdata;
  logic [(DATA_W/8)*NUM_CH-1:0] m_wstrb;
  logic [NUM_CH-1:0]            m_addr_ok;
  logic [NUM_CH-1:0]            m_data_ok;
  logic [DATA_W-1:0]            m_rdata;

  modport master (
    output m_req, m_wr, m_size, m_addr, m_wdata, m_wstrb,
    input  m_addr_ok, m_data_ok, m_rdata
  );
  modport slave (
    input  m_req, m_wr, m_size, m_addr, m_wdata, m_wstrb,
    output m_addr_ok, m_data_ok, m_rdata
  );
endinterface

interface axi_if #(
  parameter int unsigned ID_W   = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arsize;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic                rvalid;
  logic                rready;
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awsize;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic                bvalid;
  logic                bready;

  modport master (
    output arid, araddr, arsize, arvalid, rready,
           awid, awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rid, rdata, rvalid, awready, wready, bid, bvalid
  );
  modport slave (
    input  arid, araddr, arsize, arvalid, rready,
           awid, awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rid, rdata, rvalid, awready, wready, bid, bvalid
  );
endinterface

// File: rtl/sram_axi_bridge_prio_arbiter.sv
// Fixed-priority arbiter: the highest-index active request wins; emits a
// one-hot grant and its binary index.
module prio_arbiter #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned IDX_W  = 1
) (
  input  logic [NUM_CH-1:0] req_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              any_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (req_i[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
      end
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/sram_axi_bridge.sv
// Multi-channel sram-like to single-beat AXI3 bridge, one outstanding transaction.
// Define KSEG_MAP_EN to apply the kseg virtual-to-physical address map on accept.
module sram_axi_bridge
  import mem_bridge_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
) (
  input  logic   clk,
  input  logic   rst,
  sram_if.slave  cpu,
  axi_if.master  axi
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned STRB_W = DATA_W / 8;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;

  logic [NUM_CH-1:0]   gnt;
  logic [IDX_W-1:0]    gidx;
  logic                gany;
  logic [ADDR_W-1:0]   req_addr, mapped_addr;

  logic [NUM_CH-1:0]   addr_ok, data_ok;
  logic                arvalid, rready, awvalid, wvalid, bready;

  prio_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_arb (
    .req_i (cpu.m_req),
    .gnt_o (gnt),
    .idx_o (gidx),
    .any_o (gany)
  );

  assign req_addr = cpu.m_addr[gidx*ADDR_W +: ADDR_W];
`ifdef KSEG_MAP_EN
  assign mapped_addr = ADDR_W'(kseg_map(32'(req_addr)));
`else
  assign mapped_addr = req_addr;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    id_d      = id_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    addr_ok   = '0;
    data_ok   = '0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated by rst so nothing is acknowledged that the register would drop.
        if (gany && !rst) begin
          addr_ok   = gnt;
          addr_d    = mapped_addr;
          size_d    = cpu.m_size[gidx*2 +: 2];
          wdata_d   = cpu.m_wdata[gidx*DATA_W +: DATA_W];
          wstrb_d   = cpu.m_wstrb[gidx*STRB_W +: STRB_W];
          id_d      = ID_W'(gidx);
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cpu.m_wr[gidx] ? WR_AW_W : RD_AR;
        end
      end
      RD_AR: begin
        arvalid = 1'b1;
        if (axi.arready) state_d = RD_R;
      end
      RD_R: begin
        rready = 1'b1;
        if (axi.rvalid) begin
          for (int unsigned i = 0; i < NUM_CH; i++)
            data_ok[i] = (axi.rid == ID_W'(i));
          state_d = IDLE;
        end
      end
      WR_AW_W: begin
        awvalid   = !aw_done_q;
        wvalid    = !w_done_q;
        aw_done_d = aw_done_q | (awvalid & axi.awready);
        w_done_d  = w_done_q | (wvalid & axi.wready);
        if (aw_done_d && w_done_d) state_d = WR_B;
      end
      WR_B: begin
        bready = 1'b1;
        if (axi.bvalid) begin
          for (int unsigned i = 0; i < NUM_CH; i++)
            data_ok[i] = (axi.bid == ID_W'(i));
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      id_q      <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      id_q      <= id_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign cpu.m_addr_ok = addr_ok;
  assign cpu.m_data_ok = data_ok;
  assign cpu.m_rdata   = axi.rdata;

  assign axi.arid    = id_q;
  assign axi.araddr  = addr_q;
  assign axi.arsize  = to_axi_size(size_q);
  assign axi.arvalid = arvalid;
  assign axi.rready  = rready;
  assign axi.awid    = id_q;
  assign axi.awaddr  = addr_q;
  assign axi.awsize  = to_axi_size(size_q);
  assign axi.awvalid = awvalid;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wvalid  = wvalid;
  assign axi.bready  = bready;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge; the bench plays both the CPU channels and
// the AXI slave, cycle by cycle, with hand-computed expectations.
module tb_sram_axi_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

`ifdef KSEG_MAP_EN
  localparam logic [31:0] EXP_A1 = 32'h1FAF_0004;
  localparam logic [31:0] EXP_A6 = 32'h0000_0010;
`else
  localparam logic [31:0] EXP_A1 = 32'hBFAF_0004;
  localparam logic [31:0] EXP_A6 = 32'h8000_0010;
`endif

  always #5 clk = ~clk;

  sram_if #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) cpu_bus ();
  axi_if  #(.ID_W(4), .ADDR_W(32), .DATA_W(32))   axi_bus ();

  sram_axi_bridge #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .cpu (cpu_bus),
    .axi (axi_bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    cpu_bus.m_req   = '0;
    cpu_bus.m_wr    = '0;
    cpu_bus.m_size  = '0;
    cpu_bus.m_addr  = '0;
    cpu_bus.m_wdata = '0;
    cpu_bus.m_wstrb = '0;
    axi_bus.arready = 1'b0;
    axi_bus.rid     = '0;
    axi_bus.rdata   = '0;
    axi_bus.rvalid  = 1'b0;
    axi_bus.awready = 1'b0;
    axi_bus.wready  = 1'b0;
    axi_bus.bid     = '0;
    axi_bus.bvalid  = 1'b0;

    // Reset, with a request already pending that must not be acknowledged.
    tick(); tick();
    cpu_bus.m_req = 2'b01;
    settle();
    chk("rst_addr_ok", 64'(cpu_bus.m_addr_ok), 64'd0);
    chk("rst_data_ok", 64'(cpu_bus.m_data_ok), 64'd0);
    chk("rst_valids", 64'({axi_bus.arvalid, axi_bus.awvalid, axi_bus.wvalid}), 64'd0);
    chk("rst_readys", 64'({axi_bus.rready, axi_bus.bready}), 64'd0);
    chk("rst_araddr", 64'(axi_bus.araddr), 64'd0);
    chk("rst_arid", 64'(axi_bus.arid), 64'd0);
    cpu_bus.m_req = 2'b00;
    tick();
    rst = 1'b0;
    tick();

    // Read on ch1 from kseg1, zero-wait slave.
    cpu_bus.m_req  = 2'b10;
    cpu_bus.m_wr   = 2'b00;
    cpu_bus.m_size = 4'b10_00;
    cpu_bus.m_addr = {32'hBFAF_0004, 32'h0};
    settle();
    chk("t1_addr_ok_N", 64'(cpu_bus.m_addr_ok), 64'b10);
    tick();
    cpu_bus.m_req = 2'b00;
    axi_bus.arready = 1'b1;
    settle();
    chk("t1_arvalid", 64'(axi_bus.arvalid), 64'd1);
    chk("t1_araddr", 64'(axi_bus.araddr), 64'(EXP_A1));
    chk("t1_arid", 64'(axi_bus.arid), 64'd1);
    chk("t1_arsize", 64'(axi_bus.arsize), 64'd2);
    tick();
    axi_bus.arready = 1'b0;
    settle();
    chk("t1_rready", 64'(axi_bus.rready), 64'd1);
    chk("t1_arvalid_low", 64'(axi_bus.arvalid), 64'd0);
    chk("t1_no_data_ok_N2", 64'(cpu_bus.m_data_ok), 64'd0);
    tick();
    axi_bus.rvalid = 1'b1;
    axi_bus.rid    = 4'd1;
    axi_bus.rdata  = 32'hDEAD_BEEF;
    settle();
    chk("t1_data_ok_N3", 64'(cpu_bus.m_data_ok), 64'b10);
    chk("t1_rdata", 64'(cpu_bus.m_rdata), 64'hDEAD_BEEF);
    tick();
    axi_bus.rvalid = 1'b0;

    // ch0 read and ch1 write together: ch1 wins, ch0 waits for IDLE re-entry.
    cpu_bus.m_req   = 2'b11;
    cpu_bus.m_wr    = 2'b10;
    cpu_bus.m_size  = 4'b10_10;
    cpu_bus.m_addr  = {32'h0000_2000, 32'h0000_1000};
    cpu_bus.m_wdata = {32'h1234_5678, 32'h0};
    cpu_bus.m_wstrb = 8'hF0;
    settle();
    chk("t2_grant_ch1", 64'(cpu_bus.m_addr_ok), 64'b10);
    tick();
    cpu_bus.m_req   = 2'b01;
    axi_bus.awready = 1'b1;
    axi_bus.wready  = 1'b1;
    settle();
    chk("t2_busy_addr_ok", 64'(cpu_bus.m_addr_ok), 64'd0);
    chk("t2_aw_w_valid", 64'({axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid}), 64'b110);
    chk("t2_awaddr", 64'(axi_bus.awaddr), 64'h2000);
    chk("t2_wdata", 64'(axi_bus.wdata), 64'h1234_5678);
    chk("t2_wstrb", 64'(axi_bus.wstrb), 64'hF);
    chk("t2_awid", 64'(axi_bus.awid), 64'd1);
    tick();
    axi_bus.awready = 1'b0;
    axi_bus.wready  = 1'b0;
    settle();
    chk("t2_bready", 64'({axi_bus.bready, axi_bus.awvalid, axi_bus.wvalid}), 64'b100);
    chk("t2_busy_addr_ok_b", 64'(cpu_bus.m_addr_ok), 64'd0);
    tick();
    axi_bus.bvalid = 1'b1;
    axi_bus.bid    = 4'd1;
    settle();
    chk("t2_wr_data_ok", 64'(cpu_bus.m_data_ok), 64'b10);
    chk("t2_addr_ok_in_b", 64'(cpu_bus.m_addr_ok), 64'd0);
    tick();
    axi_bus.bvalid = 1'b0;
    settle();
    chk("t2_grant_ch0", 64'(cpu_bus.m_addr_ok), 64'b01);
    tick();
    cpu_bus.m_req   = 2'b00;
    axi_bus.arready = 1'b1;
    settle();
    chk("t2_ch0_araddr", 64'(axi_bus.araddr), 64'h1000);
    chk("t2_ch0_arid", 64'(axi_bus.arid), 64'd0);
    tick();
    axi_bus.arready = 1'b0;
    axi_bus.rvalid  = 1'b1;
    axi_bus.rid     = 4'd0;
    axi_bus.rdata   = 32'hCAFE_F00D;
    settle();
    chk("t2_ch0_data_ok", 64'(cpu_bus.m_data_ok), 64'b01);
    chk("t2_ch0_rdata", 64'(cpu_bus.m_rdata), 64'hCAFE_F00D);
    tick();
    axi_bus.rvalid = 1'b0;

    // Write on ch0: wready immediate, awready only after 3 cycles of awvalid.
    cpu_bus.m_req   = 2'b01;
    cpu_bus.m_wr    = 2'b01;
    cpu_bus.m_size  = 4'b00_01;
    cpu_bus.m_addr  = {32'h0, 32'h0000_3002};
    cpu_bus.m_wdata = {32'h0, 32'h0000_BEEF};
    cpu_bus.m_wstrb = 8'h0C;
    settle();
    chk("t3_grant", 64'(cpu_bus.m_addr_ok), 64'b01);
    tick();
    cpu_bus.m_req  = 2'b00;
    axi_bus.wready = 1'b1;
    settle();
    chk("t3_c1_valids", 64'({axi_bus.awvalid, axi_bus.wvalid}), 64'b11);
    chk("t3_awsize", 64'(axi_bus.awsize), 64'd1);
    tick();
    axi_bus.wready = 1'b0;
    settle();
    chk("t3_c2_valids", 64'({axi_bus.awvalid, axi_bus.wvalid}), 64'b10);
    tick();
    axi_bus.awready = 1'b1;
    settle();
    chk("t3_c3_valids", 64'({axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready}), 64'b100);
    chk("t3_c3_no_data_ok", 64'(cpu_bus.m_data_ok), 64'd0);
    tick();
    axi_bus.awready = 1'b0;
    axi_bus.bvalid  = 1'b1;
    axi_bus.bid     = 4'd0;
    settle();
    chk("t3_wr_b", 64'({axi_bus.bready, axi_bus.awvalid}), 64'b10);
    chk("t3_data_ok", 64'(cpu_bus.m_data_ok), 64'b01);
    tick();
    axi_bus.bvalid = 1'b0;

    // Read with arready low for 5 cycles, then reset while waiting in RD_R.
    cpu_bus.m_req  = 2'b10;
    cpu_bus.m_wr   = 2'b00;
    cpu_bus.m_size = 4'b10_00;
    cpu_bus.m_addr = {32'h8000_0010, 32'h0};
    settle();
    chk("t4_grant", 64'(cpu_bus.m_addr_ok), 64'b10);
    tick();
    cpu_bus.m_req = 2'b00;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("t4_arvalid_%0d", i), 64'(axi_bus.arvalid), 64'd1);
      chk($sformatf("t4_araddr_%0d", i), 64'(axi_bus.araddr), 64'(EXP_A6));
      chk($sformatf("t4_no_data_ok_%0d", i), 64'(cpu_bus.m_data_ok), 64'd0);
      tick();
    end
    axi_bus.arready = 1'b1;
    tick();
    axi_bus.arready = 1'b0;
    settle();
    chk("t5_in_rd_r", 64'(axi_bus.rready), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("t5_valids", 64'({axi_bus.arvalid, axi_bus.awvalid, axi_bus.wvalid}), 64'd0);
    chk("t5_readys", 64'({axi_bus.rready, axi_bus.bready}), 64'd0);
    chk("t5_oks", 64'({cpu_bus.m_addr_ok, cpu_bus.m_data_ok}), 64'd0);
    chk("t5_araddr", 64'(axi_bus.araddr), 64'd0);
    cpu_bus.m_req  = 2'b01;
    cpu_bus.m_addr = {32'h0, 32'h0000_0044};
    settle();
    chk("t5_new_grant", 64'(cpu_bus.m_addr_ok), 64'b01);
    tick();
    cpu_bus.m_req   = 2'b00;
    axi_bus.arready = 1'b1;
    settle();
    chk("t5_new_araddr", 64'(axi_bus.araddr), 64'h44);
    tick();
    axi_bus.arready = 1'b0;
    axi_bus.rvalid  = 1'b1;
    axi_bus.rid     = 4'd0;
    axi_bus.rdata   = 32'h0BAD_F00D;
    settle();
    chk("t5_data_ok", 64'(cpu_bus.m_data_ok), 64'b01);
    tick();
    axi_bus.rvalid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
- Parametrised successor to the single-cycle SRAM memory port of the CPU top.
- Accepts NUM_CH sram-like CPU request channels (ch0 = inst, ch1 = data by default) using a req/addr_ok/data_ok handshake.
- Arbitrates the channels and issues single-beat AXI3 read/write transactions, one outstanding at a time.
- Applies the kseg virtual-to-physical address map before issue.

Parameters:
- NUM_CH, 2, number of CPU request channels; higher index has higher priority.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be 32 or 64.
- ID_W, 4, AXI ID width; must satisfy 2**ID_W >= NUM_CH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- m_req  in  NUM_CH  per-channel request valid.
- m_wr  in  NUM_CH  1 = write, 0 = read.
- m_size  in  2*NUM_CH  transfer size: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes.
- m_addr  in  ADDR_W*NUM_CH  byte address, packed.
- m_wdata  in  DATA_W*NUM_CH  write data, packed.
- m_wstrb  in  (DATA_W/8)*NUM_CH  byte enables, packed.
- m_addr_ok  out  NUM_CH  request accepted (1-cycle pulse).
- m_data_ok  out  NUM_CH  read data valid / write complete (1-cycle pulse).
- m_rdata  out  DATA_W  read data, shared by all channels, valid while m_data_ok is high.
- arid/araddr/arsize/arvalid  out  ID_W/ADDR_W/3/1  AXI read address.
- arready  in  1
- rid/rdata/rvalid  in  ID_W/DATA_W/1
- rready  out  1
- awid/awaddr/awsize/awvalid  out  ID_W/ADDR_W/3/1  AXI write address.
- awready  in  1
- wdata/wstrb/wvalid  out  DATA_W/DATA_W/8/1
- wready  in  1
- bid/bvalid  in  ID_W/1
- bready  out  1

Behaviour:
- States: IDLE, RD_AR, RD_R, WR_AW_W, WR_B.
- Reset:
  - State goes to IDLE.
  - All *valid outputs, rready, bready, m_addr_ok and m_data_ok go to 0.
  - Address/data/ID registers go to 0.
  - Reset mid-transaction abandons it silently; the interconnect is reset by the same signal.
- IDLE:
  - If any m_req is high, grant the highest-index requester g.
  - Pulse m_addr_ok[g] in that same cycle (combinational from m_req and state).
  - Register the mapped address, size, wdata, wstrb, and ID = g.
  - Next state: RD_AR if m_wr[g] = 0, else WR_AW_W.
  - Non-granted channels see addr_ok = 0 and must hold req.
- RD_AR:
  - arvalid = 1; address, ID and size are stable.
  - On arvalid & arready go to RD_R.
- RD_R:
  - rready = 1.
  - On rvalid, m_data_ok[rid] = 1 and m_rdata = rdata in the same cycle; go to IDLE.
- WR_AW_W:
  - awvalid and wvalid are both asserted on entry.
  - Each drops independently after its own handshake (flags aw_done, w_done).
  - When both are done (the same cycle is allowed), go to WR_B.
- WR_B:
  - bready = 1.
  - On bvalid, m_data_ok[bid] = 1; go to IDLE.
- Latency:
  - Accept in cycle N; arvalid/awvalid high from N+1.
  - With a zero-wait slave, read data_ok at N+3 and write data_ok at N+3.
- A new request is accepted no earlier than the cycle after data_ok (IDLE re-entry).
- Size mapping: arsize/awsize = {1'b0, m_size}. arlen/awlen = 0, burst = INCR, wlast = 1; these are tie-offs outside the block.
- Busy: m_addr_ok is low for all channels outside IDLE.
- rid/bid never mismatch the registered ID, because only one transaction is outstanding.

Optional Feature:
- KSEG_MAP_EN defined:
  - Addresses in 0x8000_0000–0xBFFF_FFFF map to addr & 0x1FFF_FFFF.
  - All other addresses pass through unchanged.
  - Example: 0xBFAF_F000 → 0x1FAF_F000.
- KSEG_MAP_EN undefined: address passes through unmodified.

Decomposition:
- Package mem_bridge_pkg holds:
  - The state enum.
  - AXI size codes.
  - KSEG_BASE/KSEG_MASK constants.
  - The function kseg_map().
- One sub-module, prio_arbiter (parametrised by NUM_CH), produces the one-hot grant and the binary grant index.

Test Plan:
- Read, ch1, addr 0xBFAF_0004, size 2, with KSEG_MAP_EN and zero-wait slave → m_addr_ok[1] at N, araddr = 0x1FAF_0004 with arid = 1 at N+1, m_data_ok[1] at N+3 with m_rdata = slave data.
- Simultaneous ch0 read and ch1 write → ch1 granted first; ch0 addr_ok stays low until IDLE re-entry, then ch0 is granted.
- Write with awready delayed 3 cycles and wready immediate → wvalid drops after 1 cycle, awvalid held 3 cycles, then WR_B; data_ok follows bvalid.
- Read with arready held low 5 cycles → arvalid and araddr stable throughout; no data_ok pulses.
- rst asserted in RD_R → next cycle IDLE with all valids, rready, addr_ok and data_ok at 0; a new request is accepted afterwards.
- KSEG_MAP_EN undefined, addr 0x8000_0010 → araddr = 0x8000_0010.
